// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scanner.
//   GLYPH   - hex digit 0..F to segment pattern {g,f,e,d,c,b,a}, active-high
//   SEG_OFF - all segments dark, active-high
//   seg_pol - converts an active-high {dp,g..a} byte to the pin polarity
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  // al=1 selects active-low pins (common-anode style drive).
  function automatic logic [7:0] seg_pol(input logic [7:0] x, input bit al);
    return al ? ~x : x;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to seven-segment glyph.
//   nib   - hex digit value
//   glyph - segment pattern {g,f,e,d,c,b,a}, active-high
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH[nib];
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: N-digit multiplexed seven-segment scanner with a built-in
// display-source mux.  Channel 0 is a CPU-written register; channels 1..NCH-1
// are live debug taps.  The selected source is captured into a shadow register
// once per frame so every digit of a frame comes from the same value.
//   clk, rstn  - clock, synchronous active-low reset
//   we, wdata  - channel-0 register write
//   sel        - source select, taken at the frame boundary
//   ch_data    - packed sources, source i at [i*DW +: DW] (slice 0 unused)
//   lz_blank   - blank leading zero digits (digit 0 always shown)
//   blink_en   - blank everything while frame_cnt[BLINK_SH] is set
//   seg_o      - {dp,g..a}, dp never lit
//   an_o       - one-hot digit enable
//   frame_o    - one-cycle pulse as the scan wraps back to digit 0
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned NCH      = 8,
  parameter int unsigned SCAN_DIV = 17,
  parameter int unsigned BLINK_SH = 5,
  parameter bit          SEG_AL   = 1'b1,
  localparam int unsigned DW = 4 * NDIG,
  localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [DW-1:0]     wdata,
  input  logic [SW-1:0]     sel,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              lz_blank,
  input  logic              blink_en,
  output logic [7:0]        seg_o,
  output logic [NDIG-1:0]   an_o,
  output logic              frame_o
);

  logic [SCAN_DIV-1:0] cnt;
  logic [IW-1:0]       idx;
  logic [BLINK_SH:0]   frame_cnt;
  logic [DW-1:0]       ch0;
  logic [DW-1:0]       shadow;

  logic                tick;
  logic                boundary;
  logic [DW-1:0]       chan [NCH];
  logic [DW-1:0]       src;
  logic [NDIG-1:0]     lz_mask;
  logic                zero_above;
  logic [3:0]          nib;
  logic [6:0]          glyph;
  logic                blank;
  logic [NDIG-1:0]     an_next;

  always_comb begin
    tick     = &cnt;
    boundary = tick && (idx == IW'(NDIG - 1));
  end

  // Source table; entry 0 is replaced by the CPU register, and any select
  // beyond the populated channels falls back to it as well.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      chan[i] = ch_data[i*DW +: DW];
    end
    chan[0] = ch0;
    src = (32'(sel) < NCH) ? chan[sel] : ch0;
  end

  // Leading-zero mask: digit d is blankable when it and every digit above it
  // are zero.  Walk from the top digit down; digit 0 is never masked.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int unsigned k = 0; k < NDIG - 1; k++) begin
      zero_above = zero_above & (shadow[4*(NDIG-1-k) +: 4] == 4'h0);
      lz_mask[NDIG-1-k] = zero_above;
    end
  end

  always_comb begin
    nib     = shadow[{idx, 2'b00} +: 4];
    blank   = (lz_blank && lz_mask[idx]) || (blink_en && frame_cnt[BLINK_SH]);
    an_next = NDIG'(1) << idx;
  end

  seg7_hex_decode u_dec (
    .nib   (nib),
    .glyph (glyph)
  );

  // Outputs are registered from the current idx/shadow, so the display
  // trails the digit index by one cycle.  A write and a frame boundary on the
  // same edge capture the pre-write ch0 into the shadow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt       <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      ch0       <= '0;
      shadow    <= '0;
      frame_o   <= 1'b0;
      seg_o     <= seg_pol({1'b0, SEG_OFF}, SEG_AL);
      an_o      <= SEG_AL ? '1 : '0;
    end else begin
      cnt     <= cnt + 1'b1;
      frame_o <= boundary;
      if (tick) begin
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      end
      if (boundary) begin
        frame_cnt <= frame_cnt + 1'b1;
        shadow    <= src;
      end
      if (we) begin
        ch0 <= wdata;
      end
      seg_o <= seg_pol({1'b0, blank ? SEG_OFF : glyph}, SEG_AL);
      an_o  <= SEG_AL ? ~an_next : an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with SCAN_DIV=2, NDIG=8, NCH=4, BLINK_SH=1, SEG_AL=1.
// The reference model works from elapsed cycles since reset release: a digit
// slot is 4 cycles, a frame 32 cycles, and the blink phase is frames/2 mod 2.
module tb_seg7_scan_mux;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         we = 1'b0;
  logic [31:0]  wdata = '0;
  logic [1:0]   sel = '0;
  logic [127:0] ch_data = '0;
  logic         lz_blank = 1'b0;
  logic         blink_en = 1'b0;
  logic [7:0]   seg_o;
  logic [7:0]   an_o;
  logic         frame_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NDIG     (8),
    .NCH      (4),
    .SCAN_DIV (2),
    .BLINK_SH (1),
    .SEG_AL   (1'b1)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .we       (we),
    .wdata    (wdata),
    .sel      (sel),
    .ch_data  (ch_data),
    .lz_blank (lz_blank),
    .blink_en (blink_en),
    .seg_o    (seg_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  // Reference state
  int unsigned m_t = 0;
  logic [31:0] m_ch0 = '0;
  logic [31:0] m_shadow = '0;
  logic [7:0]  e_seg = 8'hFF;
  logic [7:0]  e_an = 8'hFF;
  logic        e_frame = 1'b0;

  task automatic model_edge();
    int unsigned d;
    int unsigned fc;
    logic [31:0] upper;
    logic [3:0]  n;
    bit          bl;
    if (!rstn) begin
      m_t = 0; m_ch0 = '0; m_shadow = '0;
      e_seg = 8'hFF; e_an = 8'hFF; e_frame = 1'b0;
    end else begin
      d     = (m_t / 4) % 8;
      fc    = (m_t / 32) % 4;
      upper = m_shadow >> (4 * d);
      n     = upper[3:0];
      bl    = (lz_blank && d > 0 && upper == 0) || (blink_en && fc >= 2);
      e_an    = ~(8'h01 << d);
      e_seg   = bl ? 8'hFF : ~{1'b0, FONT[n]};
      e_frame = (m_t % 32 == 31);
      if (m_t % 32 == 31)
        m_shadow = (sel == 0) ? m_ch0 : ch_data[sel*32 +: 32];
      if (we) m_ch0 = wdata;
      m_t++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("seg", seg_o, e_seg);
    chk("an", an_o, e_an);
    chk("frame", {7'b0, frame_o}, {7'b0, e_frame});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] lz_rand();
    logic [31:0] v;
    v = $urandom;
    return v >> (4 * $urandom_range(0, 8));
  endfunction

  initial begin
    bit found;

    // 1. reset, release, free-run scan of value 0
    rstn = 1'b0;
    run(3);
    chk("rst_an", an_o, 8'hFF);
    chk("rst_seg", seg_o, 8'hFF);
    rstn = 1'b1;
    step();
    chk("first_an", an_o, 8'hFE);
    chk("first_seg", seg_o, 8'hC0);
    run(4);
    chk("second_an", an_o, 8'hFD);
    run(60);

    // 2. mid-frame write to ch0
    run(10);
    we = 1'b1; wdata = 32'h1234ABCD;
    step();
    we = 1'b0;
    run(80);

    // 3. debug tap with leading-zero blanking
    ch_data[2*32 +: 32] = 32'h0000_00F0;
    ch_data[1*32 +: 32] = 32'hDEAD_0007;
    ch_data[3*32 +: 32] = 32'h0000_0000;
    sel = 2'd2; lz_blank = 1'b1;
    run(80);
    sel = 2'd3;
    run(70);
    sel = 2'd1;
    run(70);

    // 4. blink
    blink_en = 1'b1;
    run(32 * 5);
    blink_en = 1'b0; lz_blank = 1'b0; sel = 2'd0;
    run(40);

    // 5. write on the exact boundary edge
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_t % 32 == 31) found = 1;
      else step();
    end
    checks++;
    if (!found) begin errors++; $error("FAIL boundary_wait observed=timeout expected=found"); end
    we = 1'b1; wdata = 32'h0BAD_F00D;
    step();
    we = 1'b0;
    run(80);

    // 6. reset pulse at digit 5
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if ((m_t / 4) % 8 == 5) found = 1;
      else step();
    end
    checks++;
    if (!found) begin errors++; $error("FAIL idx5_wait observed=timeout expected=found"); end
    rstn = 1'b0;
    step();
    chk("midrst_an", an_o, 8'hFF);
    chk("midrst_seg", seg_o, 8'hFF);
    rstn = 1'b1;
    step();
    chk("restart_an", an_o, 8'hFE);
    chk("restart_seg", seg_o, 8'hC0);
    run(70);

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      we = ($urandom_range(0, 19) == 0);
      wdata = lz_rand();
      if ($urandom_range(0, 49) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) ch_data[32*$urandom_range(1, 3) +: 32] = lz_rand();
      if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
      rstn = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
